// File: rtl/cafe_pkg.sv
// Shared types for the coffee machine dispense sequencer:
// step states, drink codes, recipe/dose bundles and step helpers.
package cafe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AGUA,
      CAFE,
      LECHE,
      CHOCOLATE,
      AZUCAR,
      DONE
   } state_t;

   localparam logic [2:0] SEL_NEGRO     = 3'b000;
   localparam logic [2:0] SEL_CON_LECHE = 3'b001;
   localparam logic [2:0] SEL_CAPUCHINO = 3'b010;
   localparam logic [2:0] SEL_CHOCOLATE = 3'b011;
   localparam logic [2:0] SEL_AGUA      = 3'b100;

   typedef struct packed {
      logic       valid;
      logic [3:0] agua;
      logic [3:0] cafe;
      logic [3:0] leche;
      logic [3:0] choc;
   } recipe_t;

   typedef struct packed {
      logic [3:0] agua;
      logic [3:0] cafe;
      logic [3:0] leche;
      logic [3:0] choc;
      logic [3:0] azucar;
   } doses_t;

   // First step after cur with a nonzero dose; DONE when none remain.
   function automatic state_t next_step(state_t cur, doses_t d);
      state_t nxt;
      nxt = DONE;
      if (cur < AZUCAR && d.azucar != 4'd0)
         nxt = AZUCAR;
      if (cur < CHOCOLATE && d.choc != 4'd0)
         nxt = CHOCOLATE;
      if (cur < LECHE && d.leche != 4'd0)
         nxt = LECHE;
      if (cur < CAFE && d.cafe != 4'd0)
         nxt = CAFE;
      if (cur < AGUA && d.agua != 4'd0)
         nxt = AGUA;
      return nxt;
   endfunction

   function automatic logic [3:0] step_units(state_t st, doses_t d);
      logic [3:0] u;
      unique case (st)
         AGUA:      u = d.agua;
         CAFE:      u = d.cafe;
         LECHE:     u = d.leche;
         CHOCOLATE: u = d.choc;
         AZUCAR:    u = d.azucar;
         default:   u = 4'd0;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/dispense_sequencer_if.sv
// Selection/valve bundle between payment logic, sequencer
// and the machine's LED/valve outputs.
interface dispense_sequencer_if;

   logic       start;
   logic [2:0] sel;
   logic [1:0] azucar_lvl;
   logic       abort;
   logic       led_agua;
   logic       led_cafe;
   logic       led_leche;
   logic       led_chocolate;
   logic       led_azucar;
   logic       busy;
   logic       enable_fin;
   logic       err;
   logic       aborted;

   modport master (
      output start, sel, azucar_lvl, abort,
      input  led_agua, led_cafe, led_leche,
      input  led_chocolate, led_azucar,
      input  busy, enable_fin, err, aborted
   );

   modport slave (
      input  start, sel, azucar_lvl, abort,
      output led_agua, led_cafe, led_leche,
      output led_chocolate, led_azucar,
      output busy, enable_fin, err, aborted
   );

endinterface

// File: rtl/recipe_rom.sv
// Drink code to per-ingredient dosing units (agua/cafe/leche/choc).
// Unknown codes return an all-zero, invalid recipe.
import cafe_pkg::*;

module recipe_rom (
   input  logic [2:0] sel,
   output recipe_t    recipe
);

   always_comb begin
      recipe = '0;
      case (sel)
         SEL_NEGRO:     recipe = '{1'b1, 4'd4, 4'd2, 4'd0, 4'd0};
         SEL_CON_LECHE: recipe = '{1'b1, 4'd2, 4'd2, 4'd3, 4'd0};
         SEL_CAPUCHINO: recipe = '{1'b1, 4'd1, 4'd2, 4'd4, 4'd1};
         SEL_CHOCOLATE: recipe = '{1'b1, 4'd2, 4'd0, 4'd3, 4'd3};
         SEL_AGUA:      recipe = '{1'b1, 4'd6, 4'd0, 4'd0, 4'd0};
         default:       recipe = '0;
      endcase
   end

endmodule

// File: rtl/dispense_sequencer.sv
// Opens one ingredient valve at a time for the latched recipe,
// then pulses enable_fin; abort cancels an active sequence.
import cafe_pkg::*;

module dispense_sequencer #(
   parameter int TICKS_PER_UNIT = 50_000_000
) (
   input logic           clk_fpga,
   input logic           rst,
   dispense_sequencer_if.slave bus
);

   localparam int TW =
      (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);

   state_t        state;
   state_t        state_nxt;
   doses_t        doses;
   doses_t        doses_nxt;
   recipe_t       recipe;
   logic [TW-1:0] tick;
   logic [3:0]    units;
   logic          load;
   logic          run;
   logic          step_end;
   logic          err_nxt;
   logic          abort_nxt;
   logic          agua;
   logic          cafe;
   logic          leche;
   logic          choc;
   logic          azucar;
   logic          busy;
   logic          fin;
   logic          err;
   logic          aborted;

   recipe_rom u_rom (
      .sel    (bus.sel),
      .recipe (recipe)
   );

   assign step_end = (tick == TICK_LAST) && (units == 4'd1);

   always_comb begin
      state_nxt = state;
      doses_nxt = doses;
      load      = 1'b0;
      run       = 1'b0;
      err_nxt   = 1'b0;
      abort_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (recipe.valid) begin
                  doses_nxt = '{recipe.agua, recipe.cafe,
                                recipe.leche, recipe.choc,
                                {2'b00, bus.azucar_lvl}};
                  state_nxt = next_step(IDLE, doses_nxt);
                  load      = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         DONE: state_nxt = IDLE;
         default: begin
            // abort beats a step's final tick
            if (bus.abort) begin
               state_nxt = IDLE;
               abort_nxt = 1'b1;
            end else begin
               run = 1'b1;
               if (step_end) begin
                  state_nxt = next_step(state, doses);
                  load      = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_fpga or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         doses   <= '0;
         tick    <= '0;
         units   <= '0;
         agua    <= 1'b0;
         cafe    <= 1'b0;
         leche   <= 1'b0;
         choc    <= 1'b0;
         azucar  <= 1'b0;
         busy    <= 1'b0;
         fin     <= 1'b0;
         err     <= 1'b0;
         aborted <= 1'b0;
      end else begin
         state <= state_nxt;
         doses <= doses_nxt;
         if (load) begin
            tick  <= '0;
            units <= step_units(state_nxt, doses_nxt);
         end else if (run) begin
            if (tick == TICK_LAST) begin
               tick  <= '0;
               units <= units - 4'd1;
            end else begin
               tick <= tick + 1'b1;
            end
         end
         // outputs decode the state being entered
         agua    <= (state_nxt == AGUA);
         cafe    <= (state_nxt == CAFE);
         leche   <= (state_nxt == LECHE);
         choc    <= (state_nxt == CHOCOLATE);
         azucar  <= (state_nxt == AZUCAR);
         busy    <= (state_nxt != IDLE);
         fin     <= (state_nxt == DONE);
         err     <= err_nxt;
         aborted <= abort_nxt;
      end
   end

   assign bus.led_agua      = agua;
   assign bus.led_cafe      = cafe;
   assign bus.led_leche     = leche;
   assign bus.led_chocolate = choc;
   assign bus.led_azucar    = azucar;
   assign bus.busy          = busy;
   assign bus.enable_fin    = fin;
   assign bus.err           = err;
   assign bus.aborted       = aborted;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Randomized bench for dispense_sequencer against a per-cycle
// output trace built from the drink recipes.
module tb_dispense_sequencer;

   localparam int T = 2;

   logic clk_fpga = 1'b0;
   logic rst      = 1'b0;

   always #5 clk_fpga = ~clk_fpga;

   dispense_sequencer_if bus ();

   dispense_sequencer #(.TICKS_PER_UNIT(T)) dut (
      .clk_fpga (clk_fpga),
      .rst      (rst),
      .bus      (bus)
   );

   int errors = 0;
   int checks = 0;

   // bits: agua cafe leche choc azucar busy fin err aborted
   logic [8:0] exp_q [$];

   int rec [5][4] = '{
      '{4, 2, 0, 0},
      '{2, 2, 3, 0},
      '{1, 2, 4, 1},
      '{2, 0, 3, 3},
      '{6, 0, 0, 0}
   };

   function logic [8:0] outs();
      return {bus.led_agua, bus.led_cafe, bus.led_leche,
              bus.led_chocolate, bus.led_azucar,
              bus.busy, bus.enable_fin, bus.err, bus.aborted};
   endfunction

   task automatic check(input string tag,
                        input logic [8:0] got,
                        input logic [8:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%b want=%b", tag, got, want);
      end
   endtask

   // Index c = outputs seen in cycle c after a start in cycle 0;
   // the last entry is the first cycle back in IDLE.
   function automatic void build(input int sel, input int lvl,
                                 input int k);
      int u [5];
      int s;
      exp_q.delete();
      exp_q.push_back(9'h000);
      if (sel > 4) begin
         exp_q.push_back(9'h002);
         return;
      end
      for (int i = 0; i < 4; i++) u[i] = rec[sel][i];
      u[4] = lvl;
      s = 0;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < u[i] * T; j++)
            exp_q.push_back((9'h100 >> i) | 9'h008);
         s += u[i] * T;
      end
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h000);
      if (k >= 1 && k <= s) begin
         while (exp_q.size() > k + 1) void'(exp_q.pop_back());
         exp_q.push_back(9'h001);
      end
   endfunction

   task automatic run_drink(input string tag, input int sel,
                            input int lvl, input int k,
                            input bit noise, input int rst_cyc);
      build(sel, lvl, k);
      bus.start      = 1'b1;
      bus.sel        = 3'(sel);
      bus.azucar_lvl = 2'(lvl);
      bus.abort      = (k == 0);
      for (int c = 1; c < exp_q.size(); c++) begin
         @(negedge clk_fpga);
         check($sformatf("%s c%0d", tag, c), outs(), exp_q[c]);
         bus.start = 1'b0;
         bus.abort = (c == k);
         if (noise && exp_q[c][3] &&
             (c == 2 || $urandom_range(0, 3) == 0)) begin
            bus.start      = 1'b1;
            bus.sel        = (c == 2) ? 3'd4 : 3'($urandom);
            bus.azucar_lvl = 2'($urandom);
         end
         if (c == rst_cyc) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
            #1 rst = 1'b0;
            #1 check($sformatf("%s async", tag), outs(), 9'h000);
            @(negedge clk_fpga);
            check($sformatf("%s held", tag), outs(), 9'h000);
            rst = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int sel;
      int lvl;
      int k;
      bus.start      = 1'b0;
      bus.sel        = 3'd0;
      bus.azucar_lvl = 2'd0;
      bus.abort      = 1'b0;
      repeat (2) @(negedge clk_fpga);
      check("reset", outs(), 9'h000);
      rst = 1'b1;
      @(negedge clk_fpga);
      check("idle", outs(), 9'h000);

      run_drink("negro", 0, 1, -1, 1'b0, -1);
      run_drink("capuchino", 2, 0, -1, 1'b0, -1);
      run_drink("invalid", 6, 0, -1, 1'b0, -1);
      run_drink("abort", 1, 2, 6, 1'b0, -1);
      run_drink("ignored", 3, 3, -1, 1'b1, -1);
      run_drink("rst", 1, 1, -1, 1'b0, 11);
      run_drink("after_rst", 0, 3, -1, 1'b0, -1);
      run_drink("agua", 4, 2, -1, 1'b0, -1);

      for (int n = 0; n < 30; n++) begin
         sel = $urandom_range(0, 7);
         lvl = $urandom_range(0, 3);
         k   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
         run_drink($sformatf("rand%0d", n), sel, lvl, k, 1'b1, -1);
      end

      @(negedge clk_fpga);
      check("final idle", outs(), 9'h000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
